// File: rtl/mem_test_pkg.sv
// ---------------------------------------------------------------------------
// mem_test_pkg
//   Shared types and constants for the memory data-bus walking-bit test.
//   t_mtdb_state : sequencer states of mem_test_data_bus_ctrl
//   DIR_RIGHT    : walk MSB->LSB
//   DIR_LEFT     : walk LSB->MSB
// ---------------------------------------------------------------------------
package mem_test_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    CHECK = 3'd3,
    NEXT  = 3'd4,
    DONE  = 3'd5
  } t_mtdb_state;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/mem_test_data_bus_ctrl_shifter.sv
// ---------------------------------------------------------------------------
// mem_test_data_bus_ctrl_shifter
//   Combinational logical shifter used to advance the walking-bit pattern.
//   i_value   : value to shift
//   i_RL      : 1 shift left, 0 shift right
//   i_shifter : shift amount
//   o_value   : shifted value (zero fill)
//   o_zero    : shifted value is all zero, i.e. i_value held the last bit
// ---------------------------------------------------------------------------
module mem_test_data_bus_ctrl_shifter #(
  parameter int unsigned p_WIDTH_DATA     = 8,
  parameter int unsigned p_NUMBER_SHIFTER = 3
) (
  input  logic [p_WIDTH_DATA-1:0]     i_value,
  input  logic                        i_RL,
  input  logic [p_NUMBER_SHIFTER-1:0] i_shifter,
  output logic [p_WIDTH_DATA-1:0]     o_value,
  output logic                        o_zero
);

  assign o_value = i_RL ? (i_value << i_shifter) : (i_value >> i_shifter);
  assign o_zero  = ~|o_value;

endmodule

// File: rtl/mem_test_data_bus_ctrl.sv
// ---------------------------------------------------------------------------
// mem_test_data_bus_ctrl
//   Walking-bit data-bus test sequencer. A one-hot pattern is written to a
//   single address over a req/ack port, read back and compared, then shifted
//   one position until it falls off the bus. Stops at the first mismatch or
//   ack timeout.
//   i_clk, i_rst_n        : clock, async active-low reset
//   i_start/i_dir/i_addr  : start pulse, walk direction, test address (IDLE only)
//   o_busy/o_done         : test in progress / 1-cycle end pulse
//   o_pass/o_timeout      : sticky results, cleared on start
//   o_fail_pattern/_data  : failing pattern and its read-back value
//   o_mem_*/i_mem_*       : memory req/ack port
// ---------------------------------------------------------------------------
module mem_test_data_bus_ctrl
  import mem_test_pkg::*;
#(
  parameter int unsigned p_WIDTH_DATA     = 8,
  parameter int unsigned p_WIDTH_ADDR     = 16,
  parameter int unsigned p_NUMBER_SHIFTER = 3,
  parameter int unsigned p_TIMEOUT        = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic                    i_dir,
  input  logic [p_WIDTH_ADDR-1:0] i_addr,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_pass,
  output logic                    o_timeout,
  output logic [p_WIDTH_DATA-1:0] o_fail_pattern,
  output logic [p_WIDTH_DATA-1:0] o_fail_data,
  output logic                    o_mem_req,
  output logic                    o_mem_we,
  output logic [p_WIDTH_ADDR-1:0] o_mem_addr,
  output logic [p_WIDTH_DATA-1:0] o_mem_wdata,
  input  logic                    i_mem_ack,
  input  logic [p_WIDTH_DATA-1:0] i_mem_rdata
);

  localparam int unsigned CNT_W = $clog2(p_TIMEOUT);
  localparam logic [p_WIDTH_DATA-1:0] PAT_LSB = p_WIDTH_DATA'(1);
  localparam logic [p_WIDTH_DATA-1:0] PAT_MSB = PAT_LSB << (p_WIDTH_DATA - 1);

  t_mtdb_state             state_q, state_d;
  logic                    dir_q;
  logic [p_WIDTH_ADDR-1:0] addr_q;
  logic [p_WIDTH_DATA-1:0] pattern_q;
  logic [p_WIDTH_DATA-1:0] rdata_q;
  logic                    req_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    pass_q;
  logic                    timeout_q;
  logic [p_WIDTH_DATA-1:0] fail_pattern_q;
  logic [p_WIDTH_DATA-1:0] fail_data_q;

  logic [p_WIDTH_DATA-1:0] shift_value;
  logic                    shift_zero;
  logic                    ack_ok;
  logic                    tmo;
  logic                    mismatch;

  mem_test_data_bus_ctrl_shifter #(
    .p_WIDTH_DATA     (p_WIDTH_DATA),
    .p_NUMBER_SHIFTER (p_NUMBER_SHIFTER)
  ) u_shifter (
    .i_value   (pattern_q),
    .i_RL      (dir_q),
    .i_shifter (p_NUMBER_SHIFTER'(1)),
    .o_value   (shift_value),
    .o_zero    (shift_zero)
  );

  // An ack only counts while a request is outstanding.
  assign ack_ok   = req_q & i_mem_ack;
  assign tmo      = req_q & ~i_mem_ack & (cnt_q == CNT_W'(p_TIMEOUT - 1));
  assign mismatch = (rdata_q != pattern_q);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    // NOTE: assign a default before any branch so no path leaves state_d
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_start) state_d = WRITE;
      WRITE:   if (ack_ok) state_d = READ;  else if (tmo) state_d = DONE;
      READ:    if (ack_ok) state_d = CHECK; else if (tmo) state_d = DONE;
      CHECK:   state_d = (mismatch || shift_zero) ? DONE : NEXT;
      NEXT:    state_d = WRITE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_busy   = (state_q != IDLE) && (state_q != DONE);
    o_done   = (state_q == DONE);
    o_mem_we = (state_q == WRITE);
  end

  // Datapath. req_q is registered and cleared on the ack edge, so every
  // WRITE/READ entry spends one cycle with req low: this gives the idle cycle
  // between transactions and keeps all memory-port outputs glitch-free.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dir_q          <= DIR_RIGHT;
      addr_q         <= '0;
      pattern_q      <= '0;
      rdata_q        <= '0;
      req_q          <= 1'b0;
      cnt_q          <= '0;
      pass_q         <= 1'b0;
      timeout_q      <= 1'b0;
      fail_pattern_q <= '0;
      fail_data_q    <= '0;
    end else begin
      req_q <= ((state_q == WRITE) || (state_q == READ)) && !ack_ok && !tmo;
      cnt_q <= (req_q && !i_mem_ack && !tmo) ? cnt_q + 1'b1 : '0;

      if (tmo) begin
        timeout_q      <= 1'b1;
        pass_q         <= 1'b0;
        fail_pattern_q <= pattern_q;
        fail_data_q    <= '0;
      end

      case (state_q)
        IDLE: begin
          if (i_start) begin
            dir_q          <= i_dir;
            addr_q         <= i_addr;
            pattern_q      <= (i_dir == DIR_LEFT) ? PAT_LSB : PAT_MSB;
            pass_q         <= 1'b0;
            timeout_q      <= 1'b0;
            fail_pattern_q <= '0;
            fail_data_q    <= '0;
          end
        end
        READ: begin
          if (ack_ok) rdata_q <= i_mem_rdata;
        end
        CHECK: begin
          if (mismatch) begin
            fail_pattern_q <= pattern_q;
            fail_data_q    <= rdata_q;
            pass_q         <= 1'b0;
          end else if (shift_zero) begin
            pass_q <= 1'b1;
          end
        end
        NEXT:    pattern_q <= shift_value;
        default: ;
      endcase
    end
  end

  assign o_pass         = pass_q;
  assign o_timeout      = timeout_q;
  assign o_fail_pattern = fail_pattern_q;
  assign o_fail_data    = fail_data_q;
  assign o_mem_req      = req_q;
  assign o_mem_addr     = addr_q;
  assign o_mem_wdata    = pattern_q;

endmodule
